// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - CDB payload type and FU/ROB-facing arbiter bus
package cdb_pkg;
  localparam int NUM_CDB              = 2;
  localparam int NUM_ROB_ENTRIES      = 64;
  localparam int NUM_ROB_ENTRIES_BITS = 6;

  typedef struct packed {
    logic                            valid;
    logic [NUM_ROB_ENTRIES_BITS-1:0] rob_num;
    logic [31:0]                     value;
  } cdb_t;
endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU     = 4,
  parameter int NCDB       = cdb_pkg::NUM_CDB,
  parameter int DEPTH_BITS = cdb_pkg::NUM_ROB_ENTRIES_BITS
);
  logic [NUM_FU-1:0]          fu_valid;
  cdb_pkg::cdb_t              fu_result [NUM_FU];
  logic [NUM_FU-1:0]          fu_ready;
  logic [DEPTH_BITS-1:0]      rob_number_head;
  logic                       mispredict;
  cdb_pkg::cdb_t              cdb_out [NCDB];
  logic [$clog2(NCDB+1)-1:0]  grant_cnt;

  modport master (
    output fu_valid, fu_result, rob_number_head, mispredict,
    input  fu_ready, cdb_out, grant_cnt
  );

  modport slave (
    input  fu_valid, fu_result, rob_number_head, mispredict,
    output fu_ready, cdb_out, grant_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - oldest-first CDB lane arbiter with registered broadcast
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int NCDB       = cdb_pkg::NUM_CDB,
  parameter int DEPTH      = cdb_pkg::NUM_ROB_ENTRIES,
  parameter int DEPTH_BITS = cdb_pkg::NUM_ROB_ENTRIES_BITS
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int RANK_W = $clog2(NUM_FU) + 1;
  localparam int CNT_W  = $clog2(NCDB + 1);
  localparam logic [RANK_W-1:0]     NCDB_R   = RANK_W'(NCDB);
  localparam logic [DEPTH_BITS-1:0] AGE_MASK = DEPTH_BITS'(DEPTH - 1);

  logic [DEPTH_BITS-1:0] age  [NUM_FU];
  logic [RANK_W-1:0]     rank [NUM_FU];
  logic [NUM_FU-1:0]     ready;
  logic [CNT_W-1:0]      cnt;
  cdb_pkg::cdb_t         lane_d [NCDB];

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      age[i] = (bus.fu_result[i].rob_num - bus.rob_number_head) & AGE_MASK;
    end
  end

  // Rank = number of valid requesters strictly older (ties go to the lower index).
  // Ranks of valid requesters are unique, so rank doubles as the lane index.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      rank[i] = '0;
      for (int j = 0; j < NUM_FU; j++) begin
        if (j != i && bus.fu_valid[j] &&
            (age[j] < age[i] || (age[j] == age[i] && j < i))) begin
          rank[i] = rank[i] + RANK_W'(1);
        end
      end
      ready[i] = bus.fu_valid[i] && !rst && !bus.mispredict && (rank[i] < NCDB_R);
      cnt = cnt + CNT_W'(ready[i]);
    end
  end

  always_comb begin
    for (int l = 0; l < NCDB; l++) begin
      lane_d[l] = '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (ready[i] && rank[i] == RANK_W'(l)) begin
          lane_d[l]       = bus.fu_result[i];
          lane_d[l].valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < NCDB; l++) begin
      if (rst) begin
        bus.cdb_out[l] <= '0;
      end else begin
        bus.cdb_out[l] <= lane_d[l];
      end
    end
  end

  assign bus.fu_ready  = ready;
  assign bus.grant_cnt = cnt;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_pkg::*;
  localparam int NF = 4;
  localparam int NC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NF), .NCDB(NC), .DEPTH_BITS(6)) bus ();

  cdb_arbiter #(.NUM_FU(NF), .NCDB(NC), .DEPTH(64), .DEPTH_BITS(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic drive_fu(input int i, input bit v, input logic [5:0] rob, input logic [31:0] val);
    bus.fu_valid[i]          = v;
    bus.fu_result[i]         = '0;
    bus.fu_result[i].rob_num = rob;
    bus.fu_result[i].value   = val;
  endtask

  task automatic clear_fus();
    for (int i = 0; i < NF; i++) drive_fu(i, 1'b0, 6'd0, 32'd0);
  endtask

  task automatic test_reset();
    clear_fus();
    bus.rob_number_head = 6'd0;
    bus.mispredict      = 1'b0;
    drive_fu(0, 1'b1, 6'd5, 32'h55);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.fu_ready !== 4'b0000 || bus.grant_cnt !== 2'd0) begin
        errors++;
        $display("FAIL reset_ready cyc%0d: fu_ready=%b grant_cnt=%0d, required 0000/0", c, bus.fu_ready, bus.grant_cnt);
      end
      @(posedge clk); #1;
      vectors++;
      if (bus.cdb_out[0] !== '0 || bus.cdb_out[1] !== '0) begin
        errors++;
        $display("FAIL reset_cdb cyc%0d: lane0=%h lane1=%h, required 0", c, bus.cdb_out[0], bus.cdb_out[1]);
      end
    end
    clear_fus();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.fu_ready !== 4'b0000 || bus.grant_cnt !== 2'd0) begin
      errors++;
      $display("FAIL empty_ready: fu_ready=%b grant_cnt=%0d, required 0000/0", bus.fu_ready, bus.grant_cnt);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.cdb_out[0].valid !== 1'b0 || bus.cdb_out[1].valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_cdb: lane0=%h lane1=%h, required invalid", bus.cdb_out[0], bus.cdb_out[1]);
    end
  endtask

  task automatic test_oldest_first();
    bus.rob_number_head = 6'd0;
    drive_fu(0, 1'b1, 6'd7, 32'h70);
    drive_fu(1, 1'b1, 6'd3, 32'h30);
    drive_fu(2, 1'b1, 6'd9, 32'h90);
    drive_fu(3, 1'b1, 6'd1, 32'h10);
    @(negedge clk);
    vectors++;
    if (bus.fu_ready !== 4'b1010 || bus.grant_cnt !== 2'd2) begin
      errors++;
      $display("FAIL oldest_ready: fu_ready=%b grant_cnt=%0d, required 1010/2", bus.fu_ready, bus.grant_cnt);
    end
    @(posedge clk); #1;
    clear_fus();
    vectors++;
    if (bus.cdb_out[0] !== {1'b1, 6'd1, 32'h10} || bus.cdb_out[1] !== {1'b1, 6'd3, 32'h30}) begin
      errors++;
      $display("FAIL oldest_lanes: lane0=%h lane1=%h, required rob 1 then rob 3", bus.cdb_out[0], bus.cdb_out[1]);
    end
  endtask

  task automatic test_wrap();
    bus.rob_number_head = 6'd62;
    drive_fu(0, 1'b1, 6'd2,  32'h2);
    drive_fu(1, 1'b1, 6'd63, 32'h63);
    drive_fu(2, 1'b1, 6'd0,  32'h0);
    @(negedge clk);
    vectors++;
    if (bus.fu_ready !== 4'b0110) begin
      errors++;
      $display("FAIL wrap_ready: fu_ready=%b, required 0110", bus.fu_ready);
    end
    @(posedge clk); #1;
    drive_fu(1, 1'b0, 6'd0, 32'd0);
    drive_fu(2, 1'b0, 6'd0, 32'd0);
    vectors++;
    if (bus.cdb_out[0].rob_num !== 6'd63 || bus.cdb_out[1].rob_num !== 6'd0 ||
        bus.cdb_out[0].valid !== 1'b1 || bus.cdb_out[1].valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_lanes: lane0=%h lane1=%h, required rob 63 then rob 0", bus.cdb_out[0], bus.cdb_out[1]);
    end
    @(negedge clk);
    vectors++;
    if (bus.fu_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_late_ready: fu_ready=%b, required 0001", bus.fu_ready);
    end
    @(posedge clk); #1;
    clear_fus();
    vectors++;
    if (bus.cdb_out[0] !== {1'b1, 6'd2, 32'h2} || bus.cdb_out[1] !== '0) begin
      errors++;
      $display("FAIL wrap_late_lanes: lane0=%h lane1=%h, required rob 2 then empty", bus.cdb_out[0], bus.cdb_out[1]);
    end
  endtask

  task automatic test_single();
    bus.rob_number_head = 6'd4;
    drive_fu(3, 1'b1, 6'd10, 32'hABCD_1234);
    @(negedge clk);
    vectors++;
    if (bus.fu_ready !== 4'b1000 || bus.grant_cnt !== 2'd1) begin
      errors++;
      $display("FAIL single_ready: fu_ready=%b grant_cnt=%0d, required 1000/1", bus.fu_ready, bus.grant_cnt);
    end
    @(posedge clk); #1;
    clear_fus();
    vectors++;
    if (bus.cdb_out[0] !== {1'b1, 6'd10, 32'hABCD_1234} || bus.cdb_out[1] !== '0) begin
      errors++;
      $display("FAIL single_lanes: lane0=%h lane1=%h, required FU3 payload then empty", bus.cdb_out[0], bus.cdb_out[1]);
    end
  endtask

  task automatic test_mispredict();
    bus.rob_number_head = 6'd0;
    drive_fu(0, 1'b1, 6'd8, 32'h8);
    drive_fu(1, 1'b1, 6'd6, 32'h6);
    bus.mispredict = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.fu_ready !== 4'b0000 || bus.grant_cnt !== 2'd0) begin
      errors++;
      $display("FAIL mispredict_ready: fu_ready=%b grant_cnt=%0d, required 0000/0", bus.fu_ready, bus.grant_cnt);
    end
    @(posedge clk); #1;
    bus.mispredict = 1'b0;
    vectors++;
    if (bus.cdb_out[0] !== '0 || bus.cdb_out[1] !== '0) begin
      errors++;
      $display("FAIL mispredict_cdb: lane0=%h lane1=%h, required 0", bus.cdb_out[0], bus.cdb_out[1]);
    end
    @(negedge clk);
    vectors++;
    if (bus.fu_ready !== 4'b0011) begin
      errors++;
      $display("FAIL post_flush_ready: fu_ready=%b, required 0011", bus.fu_ready);
    end
    @(posedge clk); #1;
    clear_fus();
  endtask

  task automatic test_random();
    bit          pend [NF];
    logic [5:0]  rob  [NF];
    logic [31:0] dat  [NF];
    bit          used [NF];
    bit          seen [int];
    int          order[$];
    logic [5:0]  alloc = 6'd20;
    int          serial = 1000;
    int          issued = 0, delivered = 0, flushed = 0, outstanding = 0;
    bit          mis;
    logic [3:0]  exp_ready;
    cdb_t        e;
    for (int i = 0; i < NF; i++) pend[i] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1; rob[i] = alloc; dat[i] = serial;
          alloc++; serial++; issued++;
        end
        drive_fu(i, pend[i], rob[i], dat[i]);
        bus.fu_result[i].valid = 1'($urandom_range(1));
      end
      bus.rob_number_head = alloc - 6'd40 - 6'($urandom_range(7));
      mis = ($urandom_range(29) == 0);
      bus.mispredict = mis;
      // Reference: repeated selection of the smallest age among pending FUs.
      order.delete();
      for (int i = 0; i < NF; i++) used[i] = 1'b0;
      for (int k = 0; k < NC && !mis; k++) begin
        int best = -1;
        int best_age = 0;
        for (int i = 0; i < NF; i++) begin
          int a = int'(6'(rob[i] - bus.rob_number_head));
          if (pend[i] && !used[i] && (best < 0 || a < best_age)) begin
            best = i; best_age = a;
          end
        end
        if (best >= 0) begin
          used[best] = 1'b1;
          order.push_back(best);
        end
      end
      exp_ready = '0;
      foreach (order[k]) exp_ready[order[k]] = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.fu_ready !== exp_ready || bus.grant_cnt !== 2'(order.size())) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: fu_ready=%b grant_cnt=%0d, required %b/%0d", c, bus.fu_ready, bus.grant_cnt, exp_ready, order.size());
      end
      @(posedge clk); #1;
      for (int l = 0; l < NC; l++) begin
        e = '0;
        if (l < order.size()) begin
          e.valid = 1'b1; e.rob_num = rob[order[l]]; e.value = dat[order[l]];
        end
        vectors++;
        if (bus.cdb_out[l] !== e) begin
          errors++;
          $display("FAIL rand_lane%0d cyc%0d: got %h, required %h", l, c, bus.cdb_out[l], e);
        end
      end
      foreach (order[k]) begin
        vectors++;
        if (seen.exists(int'(dat[order[k]]))) begin
          errors++;
          $display("FAIL rand_dup cyc%0d: value %0d delivered twice, required once", c, dat[order[k]]);
        end
        seen[int'(dat[order[k]])] = 1'b1;
        pend[order[k]] = 1'b0;
        delivered++;
      end
      if (mis) begin
        for (int i = 0; i < NF; i++) if (pend[i]) begin pend[i] = 1'b0; flushed++; end
      end
    end
    for (int i = 0; i < NF; i++) if (pend[i]) outstanding++;
    bus.mispredict = 1'b0;
    clear_fus();
    vectors++;
    if (issued != delivered + flushed + outstanding) begin
      errors++;
      $display("FAIL rand_conservation: delivered+flushed+pending=%0d, required issued=%0d", delivered + flushed + outstanding, issued);
    end
  endtask

  initial begin
    test_reset();
    test_oldest_first();
    test_wrap();
    test_single();
    test_mispredict();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
